// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the HI/LO stage: ALU opcodes and the divider state encoding.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_MULT  = 5'd19;
  localparam logic [4:0] ALU_MADD  = 5'd20;
  localparam logic [4:0] ALU_MADDU = 5'd21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // The three ALU opcodes whose 64-bit result lands in HI/LO.
  function automatic logic is_mult_op(input logic [4:0] op);
    return (op == ALU_MULT) || (op == ALU_MADD) || (op == ALU_MADDU);
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative 32-bit restoring divider (DIV/DIVU): one quotient bit per RUN cycle,
// sign correction in FIX. The fixed result is presented while wr_o is high.
module div_core
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] rs_i,
  input  logic [XLEN-1:0] rt_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            wr_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             fix_q;

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   dvsr_q;
  logic [XLEN-1:0]   dvnd_raw_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              zero_q;

  logic [XLEN-1:0] rs_mag;
  logic [XLEN-1:0] rt_mag;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] sub;
  logic            ge;
  logic            take;

  assign take   = (state_q == IDLE) && start_i;
  assign rs_mag = (signed_i && rs_i[XLEN-1]) ? (~rs_i + 1'b1) : rs_i;
  assign rt_mag = (signed_i && rt_i[XLEN-1]) ? (~rt_i + 1'b1) : rt_i;

  // Restoring step: shift {rem, quo} left, try subtracting the divisor from the new remainder.
  assign trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign ge    = (trial >= {1'b0, dvsr_q});
  assign sub   = trial[XLEN-1:0] - dvsr_q;

  always_comb begin
    acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    if (ge) begin
      acc_d = {sub, acc_q[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      acc_q      <= {{XLEN{1'b0}}, rs_mag};
      dvsr_q     <= rt_mag;
      dvnd_raw_q <= rs_i;
      neg_quo_q  <= signed_i && (rs_i[XLEN-1] ^ rt_i[XLEN-1]);
      neg_rem_q  <= signed_i && rs_i[XLEN-1];
      zero_q     <= (rt_i == '0);
    end else if (state_q == RUN) begin
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fix_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            cnt_q   <= CNT_LAST;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            state_q <= FIX;
            fix_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          state_q <= IDLE;
          fix_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          fix_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A zero divisor yields all-ones quotient and the untouched dividend as remainder.
  assign quo_o  = zero_q    ? {XLEN{1'b1}} :
                  neg_quo_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_o  = zero_q    ? dvnd_raw_q :
                  neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
  assign wr_o   = fix_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO special registers with MULT-class/MTHI/MTLO writes and an optional divider.
// Define HILO_DIV_EN to build in the divider, busy/stall interlock and div_done.
module hilo_unit
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      alu_ctrl,
  input  logic            wr_en,
  input  logic [XLEN-1:0] alu_hi,
  input  logic [XLEN-1:0] alu_lo,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            div_start,
  input  logic            div_signed,
  input  logic            rd_hilo,
  output logic [XLEN-1:0] hi_reg,
  output logic [XLEN-1:0] lo_reg,
  output logic            busy,
  output logic            div_done,
  output logic            stall
);

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] hi_d;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] lo_d;

  logic            mult_wr;
  logic            div_wr;
  logic            div_busy;
  logic            div_take;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;

  assign mult_wr = wr_en && is_mult_op(alu_ctrl);

`ifdef HILO_DIV_EN
  div_core #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (div_start),
    .signed_i (div_signed),
    .rs_i     (rs_data),
    .rt_i     (rt_data),
    .quo_o    (div_quo),
    .rem_o    (div_rem),
    .wr_o     (div_wr),
    .busy_o   (div_busy),
    .done_o   (div_done)
  );

  // A launching divide owns HI/LO, so a same-cycle pipeline write is discarded.
  assign div_take = div_start;
  assign busy     = div_busy;
  assign stall    = div_busy && (div_start || rd_hilo ||
                                 (wr_en && (mthi || mtlo || is_mult_op(alu_ctrl))));
`else
  localparam int unused_div_cycles = DIV_CYCLES;
  logic unused_div_inputs;

  assign unused_div_inputs = ^{div_start, div_signed, rt_data, rd_hilo};
  assign div_take = 1'b0;
  assign div_wr   = 1'b0;
  assign div_busy = 1'b0;
  assign div_quo  = '0;
  assign div_rem  = '0;
  assign busy     = 1'b0;
  assign div_done = 1'b0;
  assign stall    = 1'b0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_wr) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end else if (!div_busy && !div_take) begin
      if (mult_wr) begin
        hi_d = alu_hi;
        lo_d = alu_lo;
      end else if (wr_en && mthi) begin
        hi_d = rs_data;
      end else if (wr_en && mtlo) begin
        lo_d = rs_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_reg = hi_q;
  assign lo_reg = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed scoreboard bench for hilo_unit; divider checks build when HILO_DIV_EN is defined.
module tb_hilo_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  alu_ctrl;
  logic        wr_en;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        div_start;
  logic        div_signed;
  logic        rd_hilo;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        busy;
  logic        div_done;
  logic        stall;

  hilo_unit #(.DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_ctrl   (alu_ctrl),
    .wr_en      (wr_en),
    .alu_hi     (alu_hi),
    .alu_lo     (alu_lo),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .div_start  (div_start),
    .div_signed (div_signed),
    .rd_hilo    (rd_hilo),
    .hi_reg     (hi_reg),
    .lo_reg     (lo_reg),
    .busy       (busy),
    .div_done   (div_done),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'h0;
  logic [31:0] m_lo  = 32'h0;
  int          cyc;
  int          bcyc;
  int          dcnt;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [31:0] rq;
  logic [31:0] rr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  task automatic idle_inputs();
    alu_ctrl   = 5'd0;
    wr_en      = 1'b0;
    alu_hi     = 32'h0;
    alu_lo     = 32'h0;
    mthi       = 1'b0;
    mtlo       = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    rd_hilo    = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    sbq.push_back(e);
    m_hi = hi;
    m_lo = lo;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".hi"}, hi_reg, e.hi);
      chk({tag, ".lo"}, lo_reg, e.lo);
    end
  endtask

  task automatic wr_op(input string tag, input logic [4:0] ctrl, input logic mh, input logic ml,
                       input logic [31:0] ahi, input logic [31:0] alo, input logic [31:0] rs,
                       input logic [31:0] want_hi, input logic [31:0] want_lo);
    alu_ctrl = ctrl;
    wr_en    = 1'b1;
    mthi     = mh;
    mtlo     = ml;
    alu_hi   = ahi;
    alu_lo   = alo;
    rs_data  = rs;
    push_exp(want_hi, want_lo);
    tick();
    idle_inputs();
    pop_chk(tag);
  endtask

  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_start  = 1'b1;
    div_signed = sgn;
    rs_data    = a;
    rt_data    = b;
    tick();
    div_start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int c, output int bc);
    c  = 0;
    bc = 0;
    while (div_done !== 1'b1 && c < 60) begin
      if (busy === 1'b1) bc++;
      tick();
      c++;
    end
    total++;
    assert (div_done === 1'b1) else begin
      bad++;
      $error("FAIL %s.done observed=%b expected=1 within 60 cycles", tag, div_done);
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want_hi,
                         input logic [31:0] want_lo);
    int c;
    int bc;
    start_div(sgn, a, b);
    push_exp(want_hi, want_lo);
    wait_done(tag, c, bc);
    pop_chk(tag);
  endtask

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  initial begin
    idle_inputs();
    rs_data = 32'h0;
    rt_data = 32'h0;
    rst_n   = 1'b0;
    tick();
    tick();
    chk("rst.hi", hi_reg, 32'h0);
    chk("rst.lo", lo_reg, 32'h0);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.done", {31'h0, div_done}, 32'h0);
    chk("rst.stall", {31'h0, stall}, 32'h0);
    rst_n = 1'b1;
    tick();

    wr_op("mult", ALU_MULT, 1'b0, 1'b0, 32'h0000DEAD, 32'h0000BEEF, 32'h0,
          32'h0000DEAD, 32'h0000BEEF);
    wr_op("madd", ALU_MADD, 1'b0, 1'b0, 32'h11223344, 32'h55667788, 32'h0,
          32'h11223344, 32'h55667788);
    wr_op("maddu", ALU_MADDU, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,
          32'hFFFFFFFF, 32'h00000001);
    wr_op("mthi", 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000001);
    wr_op("mtlo", 5'd0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A);
    wr_op("other_op18", 5'd18, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0,
          32'hA5A5A5A5, 32'h5A5A5A5A);
    wr_op("other_op22", 5'd22, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0,
          32'hA5A5A5A5, 32'h5A5A5A5A);
    wr_op("mult_over_mthi", ALU_MULT, 1'b1, 1'b1, 32'h0BAD0001, 32'h0BAD0002, 32'hCCCCCCCC,
          32'h0BAD0001, 32'h0BAD0002);
    wr_op("mthi_over_mtlo", 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h77777777,
          32'h77777777, 32'h0BAD0002);

    mthi    = 1'b1;
    mtlo    = 1'b1;
    alu_ctrl = ALU_MULT;
    rs_data = 32'h31415926;
    push_exp(m_hi, m_lo);
    tick();
    idle_inputs();
    pop_chk("no_wr_en");

`ifdef HILO_DIV_EN
    chk("idle.stall_rd", {31'h0, stall}, 32'h0);

    // DIVU 100/7 with a same-cycle MULT that must be dropped.
    wr_en    = 1'b1;
    alu_ctrl = ALU_MULT;
    alu_hi   = 32'hEEEEEEEE;
    alu_lo   = 32'hDDDDDDDD;
    start_div(1'b0, 32'd100, 32'd7);
    idle_inputs();
    chk("divu.drop_hi", hi_reg, m_hi);
    chk("divu.drop_lo", lo_reg, m_lo);
    chk("divu.busy_e0", {31'h0, busy}, 32'h1);
    push_exp(32'd2, 32'd14);
    wait_done("divu", cyc, bcyc);
    chk("divu.latency", cyc, 32'd33);
    chk("divu.busy_cycles", bcyc, 32'd33);
    chk("divu.busy_after", {31'h0, busy}, 32'h0);
    pop_chk("divu");
    tick();
    chk("divu.done_single", {31'h0, div_done}, 32'h0);

    run_div("div_neg7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_div("divu_zero", 1'b0, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);
    run_div("div_zero", 1'b1, 32'h80000001, 32'h0, 32'h80000001, 32'hFFFFFFFF);
    run_div("div_7_neg2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    // Back-to-back: second start is driven right after the first result lands.
    run_div("b2b_a", 1'b0, 32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF);
    run_div("b2b_b", 1'b0, 32'd9, 32'd10, 32'd9, 32'd0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i < 2) ? 32'($urandom_range(1, 5000)) : 32'($urandom);
      if (rb == 32'h0) rb = 32'd3;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
      ref_div(i[0], ra, rb, rq, rr);
      run_div($sformatf("rand%0d", i), i[0], ra, rb, rr, rq);
    end

    // Interlock during a divide.
    start_div(1'b0, 32'd1000, 32'd3);
    tick();
    tick();
    tick();
    tick();
    rd_hilo = 1'b1;
    #1;
    chk("lock.stall_rd", {31'h0, stall}, 32'h1);
    rd_hilo = 1'b0;
    mthi    = 1'b1;
    rs_data = 32'hCAFEF00D;
    #1;
    chk("lock.mthi_no_wr", {31'h0, stall}, 32'h0);
    wr_en = 1'b1;
    #1;
    chk("lock.stall_mthi", {31'h0, stall}, 32'h1);
    mthi     = 1'b0;
    alu_ctrl = ALU_MADDU;
    #1;
    chk("lock.stall_mult", {31'h0, stall}, 32'h1);
    wr_en     = 1'b0;
    div_start = 1'b1;
    #1;
    chk("lock.stall_start", {31'h0, stall}, 32'h1);
    div_start = 1'b0;
    wr_en     = 1'b1;
    mthi      = 1'b1;
    alu_ctrl  = 5'd0;
    rd_hilo   = 1'b1;
    tick();
    idle_inputs();
    chk("lock.hi_held", hi_reg, m_hi);
    chk("lock.lo_held", lo_reg, m_lo);
    push_exp(32'd1, 32'd333);
    wait_done("lock", cyc, bcyc);
    pop_chk("lock");
    chk("lock.stall_after", {31'h0, stall}, 32'h0);

    // Reset mid-divide.
    start_div(1'b0, 32'd5000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    chk("rstdiv.hi", hi_reg, 32'h0);
    chk("rstdiv.lo", lo_reg, 32'h0);
    chk("rstdiv.busy", {31'h0, busy}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    dcnt  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (div_done === 1'b1) dcnt++;
    end
    chk("rstdiv.no_done", dcnt, 32'd0);
    chk("rstdiv.hi_kept", hi_reg, 32'h0);
    run_div("rstdiv.fresh", 1'b0, 32'd5000, 32'd3, 32'd2, 32'd1666);
`else
    wr_en    = 1'b1;
    alu_ctrl = ALU_MULT;
    alu_hi   = 32'h00000001;
    alu_lo   = 32'h00000002;
    rd_hilo  = 1'b1;
    div_start = 1'b1;
    rs_data  = 32'd100;
    rt_data  = 32'd7;
    #1;
    chk("nodiv.stall", {31'h0, stall}, 32'h0);
    push_exp(32'h1, 32'h2);
    tick();
    idle_inputs();
    pop_chk("nodiv.mult_kept");
    chk("nodiv.busy", {31'h0, busy}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (div_done === 1'b1 || busy === 1'b1) dcnt++;
    end
    chk("nodiv.quiet", dcnt, 32'd0);
    chk("nodiv.hi_kept", hi_reg, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("nodiv.rst_hi", hi_reg, 32'h0);
    chk("nodiv.rst_lo", lo_reg, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO special-register stage sitting directly downstream of the ALU and feeding back into it. Captures 64-bit MULT/MADD/MADDU results from the ALU, services MTHI/MTLO writes, and presents the current `hi_reg`/`lo_reg` back to the ALU's HI/LO operand inputs. Also hosts a 32-iteration signed/unsigned divider (DIV/DIVU) that writes its quotient to LO and its remainder to HI, with busy/stall interlock to the pipeline.

## Interface

Parameters:
- `DIV_CYCLES`, default 32: divider iterations, one quotient bit per cycle; fixed at 32 for a 32-bit datapath.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_ctrl` in 5: ALU opcode of the committing instruction (19 MULT, 20 MADD, 21 MADDU).
- `wr_en` in 1: instruction commits this cycle.
- `alu_hi`, `alu_lo` in 32: ALU `hi_out`/`lo_out`.
- `mthi`, `mtlo` in 1: move-to-HI/LO strobes, qualified by `wr_en`.
- `rs_data`, `rt_data` in 32: dividend/divisor; `rs_data` also supplies MTHI/MTLO data.
- `div_start` in 1: launch divide.
- `div_signed` in 1: 1 = DIV, 0 = DIVU; sampled with `div_start`.
- `rd_hilo` in 1: MFHI/MFLO in the decode stage.
- `hi_reg`, `lo_reg` out 32: architectural HI/LO, fed to the ALU.
- `busy` out 1: divider running.
- `div_done` out 1: one-cycle pulse when the divide result is written.
- `stall` out 1: pipeline hold request.

## Operation

- Reset: `hi_reg`, `lo_reg` = 0; `busy`, `div_done`, `stall` = 0; FSM = IDLE. Reset asserted mid-divide aborts the divide with no result write and no `div_done`.
- Writes when not busy, highest priority first:
  1. `div_start`: any same-cycle `wr_en` write is dropped.
  2. `wr_en` with `alu_ctrl` in {19, 20, 21}: HI ← `alu_hi`, LO ← `alu_lo`.
  3. `wr_en & mthi`: HI ← `rs_data`.
  4. `wr_en & mtlo`: LO ← `rs_data`.
- Any other `alu_ctrl` value with `wr_en` leaves HI/LO unchanged.
- FSM states:
  - IDLE: `div_start` captures |rs|, |rt| (signed mode) or raw values, latches sign flags and a zero-divisor flag, loads the counter with 31, and moves to RUN.
  - RUN: one restoring-division step per edge on the 64-bit {remainder, quotient} shift register. After the step with counter 0, moves to FIX; otherwise decrements the counter.
  - FIX: applies sign correction and writes HI/LO, then returns to IDLE.
- Sign rules:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - −2³¹ / −1 gives LO = 0x80000000, HI = 0 (truncated magnitude).
- Divide by zero, both modes: LO = 0xFFFFFFFF, HI = `rs_data` as captured. Latency is unchanged.
- While `busy`: `div_start`, MULT-class writes and MTHI/MTLO are ignored. The decoder relies on `stall` to hold them.

## Timing

- `div_start` sampled at edge E0.
- `busy` = 1 from after E0 through edge E33.
- RUN occupies edges E1–E32; FIX is edge E33.
- HI/LO carry the divide result after E33; `div_done` = 1 for the single cycle following E33.
- Back-to-back divide: a new `div_start` is accepted at E34 at the earliest.
- MULT/MTHI/MTLO: one-cycle latency; visible on `hi_reg`/`lo_reg` after the write edge.
- `stall` is combinational: `busy & (div_start | rd_hilo | (wr_en & (mthi | mtlo | alu_ctrl in {19, 20, 21})))`.

## Configuration

- `HILO_DIV_EN` defined: divider and FSM compiled in, as specified above.
- `HILO_DIV_EN` undefined:
  - Divider and FSM omitted.
  - `div_start` ignored; `busy`, `div_done`, `stall` tied to 0.
  - HI/LO written only by MULT-class and MTHI/MTLO.

## Structure

- Shared package `mips_pkg`:
  - ALU opcode constants `ALU_MULT` = 5'd19, `ALU_MADD` = 5'd20, `ALU_MADDU` = 5'd21.
  - Divider state encoding IDLE/RUN/FIX.
- Sub-module `div_core`: iterative divider holding the FSM, counter, shift register and sign fix. Outputs quotient, remainder, `busy`, `done`. `hilo_unit` keeps the register file, write priority and stall logic.

## Test plan

- MULT write: `wr_en`=1, `alu_ctrl`=19, `alu_hi`=0x0000DEAD, `alu_lo`=0x0000BEEF → after one edge `hi_reg`=0x0000DEAD, `lo_reg`=0x0000BEEF.
- DIVU: `rs`=100, `rt`=7 → after E33 `lo_reg`=14, `hi_reg`=2; `div_done` pulses exactly once; `busy` high for 33 cycles.
- DIV signed: `rs`=0xFFFFFFF9 (−7), `rt`=2 → `lo_reg`=0xFFFFFFFD, `hi_reg`=0xFFFFFFFF.
- Divide by zero: `rs`=0x12345678, `rt`=0 → `lo_reg`=0xFFFFFFFF, `hi_reg`=0x12345678 at E33.
- Interlock: `rd_hilo`=1 and MTHI write at E5 of a divide → `stall`=1, HI unchanged until the divide result lands.
- Reset mid-divide: drop `rst_n` at E10 → `hi_reg`/`lo_reg`/`busy` = 0 immediately; no `div_done`; a fresh `div_start` after release completes normally.
